// File: rtl/fb_pixel_writer.sv
`default_nettype none
//==============================================================================
// Module   : fb_pixel_writer
// Purpose  : Write-side master for the 80x60 RGB framebuffer. After reset, and
//            again on request, it sweeps every framebuffer word to clear it.
//            It accepts pixel-write commands in framebuffer coordinates over a
//            valid/ready port. Each command is scaled to screen coordinates and
//            driven onto the write bus, but only during blanking. A write is
//            held for HOLD_CYCLES consecutive blanking cycles.
// Ports    : clk, reset_n       - clock, asynchronous active-low reset
//            clear_req          - one-cycle request to re-clear the framebuffer
//            clear_busy         - high while a clear sweep runs
//            cmd_valid/ready    - pixel command handshake
//            cmd_x/cmd_y/cmd_rgb- framebuffer column, row and colour
//            display_on         - active video; writes are forbidden while high
//            fb_memreset        - low while sweeping
//            fb_resetcnt        - clear-sweep address
//            fb_hpos/fb_vpos    - write position in screen pixels
//            fb_rgbin/fb_we     - write colour and write strobe
//            fb_fifoempty       - high when no write is pending or in progress
//            drop_pulse         - one-cycle pulse on a discarded command
// Revision : 1.0 - initial release
//==============================================================================
module fb_pixel_writer #(
    parameter int RAMLENGTH    = 800,
    parameter int ADDR_WIDTH   = 10,
    parameter int X_WIRE_WIDTH = 11,
    parameter int Y_WIRE_WIDTH = 10,
    parameter int FB_W         = 80,
    parameter int FB_H         = 60,
    parameter int SCALE_SHIFT  = 3,
    parameter int HOLD_CYCLES  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_req,
    output logic                    clear_busy,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [6:0]              cmd_x,
    input  logic [5:0]              cmd_y,
    input  logic [2:0]              cmd_rgb,
    input  logic                    display_on,
    output logic                    fb_memreset,
    output logic [ADDR_WIDTH-1:0]   fb_resetcnt,
    output logic [X_WIRE_WIDTH-1:0] fb_hpos,
    output logic [Y_WIRE_WIDTH-1:0] fb_vpos,
    output logic [2:0]              fb_rgbin,
    output logic                    fb_we,
    output logic                    fb_fifoempty,
    output logic                    drop_pulse
);

    localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] c_st_clear = 2'd0;
    localparam logic [1:0] c_st_idle  = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_write = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RAMLENGTH - 1);
    localparam logic [c_hold_w-1:0]   c_last_hold = c_hold_w'(HOLD_CYCLES - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_resetcnt;
    logic [ADDR_WIDTH-1:0]   w_resetcnt_nxt;
    logic [c_hold_w-1:0]     r_hold_cnt;
    logic [c_hold_w-1:0]     w_hold_nxt;
    logic                    r_clear_pend;
    logic                    w_clear_pend_nxt;
    logic [X_WIRE_WIDTH-1:0] r_hpos;
    logic [Y_WIRE_WIDTH-1:0] r_vpos;
    logic [2:0]              r_rgb;
    logic                    r_drop;

    logic w_accept;
    logic w_in_range;

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_in_range = (int'(cmd_x) < FB_W) && (int'(cmd_y) < FB_H);

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_clear;
            r_resetcnt   <= '0;
            r_hold_cnt   <= '0;
            r_clear_pend <= 1'b0;
            r_hpos       <= '0;
            r_vpos       <= '0;
            r_rgb        <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resetcnt   <= w_resetcnt_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_clear_pend <= w_clear_pend_nxt;
            r_drop       <= w_accept & ~w_in_range;
            // Write bus only changes on an accepted in-range command, so it
            // holds its last value whenever fb_we is low.
            if (w_accept && w_in_range) begin
                r_hpos <= X_WIRE_WIDTH'(cmd_x) << SCALE_SHIFT;
                r_vpos <= Y_WIRE_WIDTH'(cmd_y) << SCALE_SHIFT;
                r_rgb  <= cmd_rgb;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_resetcnt_nxt   = r_resetcnt;
        w_hold_nxt       = r_hold_cnt;
        w_clear_pend_nxt = r_clear_pend;
        case (r_state)
            c_st_clear: begin
                // Requests during a sweep are ignored; the sweep is not restarted.
                w_clear_pend_nxt = 1'b0;
                if (r_resetcnt == c_last_addr) begin
                    w_resetcnt_nxt = '0;
                    w_state_nxt    = c_st_idle;
                end else begin
                    w_resetcnt_nxt = r_resetcnt + 1'b1;
                end
            end
            c_st_idle: begin
                if (w_accept) begin
                    // A clear arriving with the command runs after the command.
                    w_clear_pend_nxt = clear_req;
                    if (w_in_range) begin
                        w_state_nxt = c_st_wait;
                    end
                end else if (clear_req || r_clear_pend) begin
                    w_clear_pend_nxt = 1'b0;
                    w_state_nxt      = c_st_clear;
                end
            end
            c_st_wait: begin
                if (clear_req) begin
                    w_clear_pend_nxt = 1'b1;
                end
                if (!display_on) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = c_st_write;
                end
            end
            c_st_write: begin
                if (clear_req) begin
                    w_clear_pend_nxt = 1'b1;
                end
                if (display_on) begin
                    // Active video interrupted the hold: restart it in full.
                    w_hold_nxt  = '0;
                    w_state_nxt = c_st_wait;
                end else if (r_hold_cnt == c_last_hold) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = (r_clear_pend || clear_req) ? c_st_clear : c_st_idle;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_clear;
            end
        endcase
    end

    // Strobe is qualified combinationally so it drops in the same cycle
    // display_on rises.
    assign fb_we        = (r_state == c_st_write) & ~display_on;
    assign clear_busy   = (r_state == c_st_clear);
    assign fb_memreset  = (r_state != c_st_clear);
    assign cmd_ready    = (r_state == c_st_idle) & ~r_clear_pend;
    assign fb_fifoempty = (r_state != c_st_wait) && (r_state != c_st_write);
    assign fb_resetcnt  = r_resetcnt;
    assign fb_hpos      = r_hpos;
    assign fb_vpos      = r_vpos;
    assign fb_rgbin     = r_rgb;
    assign drop_pulse   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
//==============================================================================
// Module   : tb_fb_pixel_writer
// Purpose  : Self-checking bench for fb_pixel_writer. It runs directed
//            scenarios and a randomized command stream. The stream is checked
//            against a transaction-level model of the blanking/hold rules.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [6:0]  cmd_x = '0;
    logic [5:0]  cmd_y = '0;
    logic [2:0]  cmd_rgb = '0;
    logic        display_on = 1'b0;
    logic        clear_busy, cmd_ready, fb_memreset, fb_we, fb_fifoempty, drop_pulse;
    logic [9:0]  fb_resetcnt;
    logic [10:0] fb_hpos;
    logic [9:0]  fb_vpos;
    logic [2:0]  fb_rgbin;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_pixel_writer dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_rgb(cmd_rgb), .display_on(display_on), .fb_memreset(fb_memreset),
        .fb_resetcnt(fb_resetcnt), .fb_hpos(fb_hpos), .fb_vpos(fb_vpos),
        .fb_rgbin(fb_rgbin), .fb_we(fb_we), .fb_fifoempty(fb_fifoempty),
        .drop_pulse(drop_pulse)
    );

    // Inputs change 1 time unit after the active edge; outputs are sampled at
    // the falling edge of the same cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(); cyc(); smp();
        n_vec++;
        if ({fb_memreset, fb_resetcnt, clear_busy, cmd_ready} !== {1'b0, 10'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_ctl: got %h expected %h",
                     {fb_memreset, fb_resetcnt, clear_busy, cmd_ready}, {1'b0, 10'd0, 1'b1, 1'b0});
        end
        n_vec++;
        if ({fb_we, fb_hpos, fb_vpos, fb_rgbin, fb_fifoempty, drop_pulse} !==
            {1'b0, 11'd0, 10'd0, 3'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_bus: got %h expected %h",
                     {fb_we, fb_hpos, fb_vpos, fb_rgbin, fb_fifoempty, drop_pulse},
                     {1'b0, 11'd0, 10'd0, 3'd0, 1'b1, 1'b0});
        end
        cyc(); reset_n = 1'b1; smp();
        for (int i = 0; i < 800; i++) begin
            if (i > 0) begin cyc(); smp(); end
            n_vec++;
            if ({fb_memreset, fb_resetcnt, cmd_ready, fb_we} !== {1'b0, 10'(i), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL sweep[%0d]: got %h expected %h", i,
                         {fb_memreset, fb_resetcnt, cmd_ready, fb_we}, {1'b0, 10'(i), 1'b0, 1'b0});
            end
        end
        cyc(); smp();
        n_vec++;
        if ({fb_memreset, fb_resetcnt, clear_busy, cmd_ready} !== {1'b1, 10'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sweep_end: got %h expected %h",
                     {fb_memreset, fb_resetcnt, clear_busy, cmd_ready}, {1'b1, 10'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_write();
        logic exp_we, exp_fe, exp_rdy;
        display_on = 1'b0;
        cyc(); cmd_valid = 1'b1; cmd_x = 7'd3; cmd_y = 6'd2; cmd_rgb = 3'b111; smp();
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL write_ready: got %b expected 1", cmd_ready);
        end
        for (int c = 1; c <= 7; c++) begin
            cyc(); cmd_valid = 1'b0; smp();
            exp_we  = (c >= 2 && c <= 6);
            exp_fe  = (c == 7);
            exp_rdy = (c == 7);
            n_vec++;
            if ({fb_we, fb_fifoempty, cmd_ready} !== {exp_we, exp_fe, exp_rdy}) begin
                n_err++;
                $display("FAIL write_cyc%0d we/fe/rdy: got %b expected %b", c,
                         {fb_we, fb_fifoempty, cmd_ready}, {exp_we, exp_fe, exp_rdy});
            end
            if (c == 1) begin
                n_vec++;
                if ({fb_hpos, fb_vpos, fb_rgbin} !== {11'd24, 10'd16, 3'd7}) begin
                    n_err++;
                    $display("FAIL write_coords: got %0d,%0d,%0d expected 24,16,7",
                             fb_hpos, fb_vpos, fb_rgbin);
                end
            end
        end
    endtask

    task automatic test_blank_interrupt();
        logic exp_we, exp_fe;
        display_on = 1'b1;
        cyc(); cmd_valid = 1'b1; cmd_x = 7'd5; cmd_y = 6'd7; cmd_rgb = 3'b010; smp();
        for (int c = 1; c <= 51; c++) begin
            cyc(); cmd_valid = 1'b0; display_on = (c <= 40) || (c == 44); smp();
            exp_we = (c == 42) || (c == 43) || (c >= 46 && c <= 50);
            exp_fe = (c == 51);
            n_vec++;
            if ({fb_we, fb_fifoempty} !== {exp_we, exp_fe}) begin
                n_err++;
                $display("FAIL blank_cyc%0d we/fe: got %b expected %b", c,
                         {fb_we, fb_fifoempty}, {exp_we, exp_fe});
            end
        end
        n_vec++;
        if ({fb_hpos, fb_vpos, fb_rgbin, cmd_ready} !== {11'd40, 10'd56, 3'd2, 1'b1}) begin
            n_err++;
            $display("FAIL blank_coords: got %0d,%0d,%0d,%b expected 40,56,2,1",
                     fb_hpos, fb_vpos, fb_rgbin, cmd_ready);
        end
    endtask

    task automatic test_drop();
        logic [6:0] xs [3];
        logic [5:0] ys [3];
        logic       oor;
        xs = '{7'd80, 7'd0, 7'd79};
        ys = '{6'd0, 6'd60, 6'd59};
        display_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            oor = (k != 2);
            cyc(); cmd_valid = 1'b1; cmd_x = xs[k]; cmd_y = ys[k]; cmd_rgb = 3'd4; smp();
            cyc(); cmd_valid = 1'b0; smp();
            n_vec++;
            if ({drop_pulse, fb_we, fb_fifoempty} !== {oor, 1'b0, oor}) begin
                n_err++;
                $display("FAIL drop%0d_c1 drop/we/fe: got %b expected %b", k,
                         {drop_pulse, fb_we, fb_fifoempty}, {oor, 1'b0, oor});
            end
            if (!oor) begin
                n_vec++;
                if ({fb_hpos, fb_vpos} !== {11'd632, 10'd472}) begin
                    n_err++;
                    $display("FAIL edge_coords: got %0d,%0d expected 632,472", fb_hpos, fb_vpos);
                end
                for (int c = 2; c <= 7; c++) begin
                    cyc(); smp();
                    n_vec++;
                    if (fb_we !== (c <= 6)) begin
                        n_err++;
                        $display("FAIL edge_we_c%0d: got %b expected %b", c, fb_we, (c <= 6));
                    end
                end
            end else begin
                cyc(); smp();
                n_vec++;
                if ({drop_pulse, fb_we, fb_fifoempty, cmd_ready} !== 4'b0011) begin
                    n_err++;
                    $display("FAIL drop%0d_c2: got %b expected 0011", k,
                             {drop_pulse, fb_we, fb_fifoempty, cmd_ready});
                end
            end
        end
    endtask

    task automatic test_clear_write();
        logic       exp_we, exp_busy;
        logic [9:0] exp_cnt;
        int         waited;
        display_on = 1'b0;
        cyc(); cmd_valid = 1'b1; cmd_x = 7'd1; cmd_y = 6'd1; cmd_rgb = 3'd1; smp();
        for (int c = 1; c <= 807; c++) begin
            cyc(); cmd_valid = 1'b0; clear_req = (c == 3) || (c == 100); smp();
            exp_we   = (c >= 2 && c <= 6);
            exp_busy = (c >= 7 && c <= 806);
            exp_cnt  = exp_busy ? 10'(c - 7) : 10'd0;
            n_vec++;
            if ({cmd_ready, fb_we, clear_busy, fb_memreset, fb_resetcnt} !==
                {(c == 807), exp_we, exp_busy, ~exp_busy, exp_cnt}) begin
                n_err++;
                $display("FAIL clrwr_c%0d rdy/we/busy/mr/cnt: got %h expected %h", c,
                         {cmd_ready, fb_we, clear_busy, fb_memreset, fb_resetcnt},
                         {(c == 807), exp_we, exp_busy, ~exp_busy, exp_cnt});
            end
        end
        clear_req = 1'b0;
        // Command and clear in the same IDLE cycle: command first, then sweep.
        cyc(); cmd_valid = 1'b1; clear_req = 1'b1; cmd_x = 7'd2; cmd_y = 6'd2; cmd_rgb = 3'd5; smp();
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL simul_ready: got %b expected 1", cmd_ready);
        end
        for (int c = 1; c <= 7; c++) begin
            cyc(); cmd_valid = 1'b0; clear_req = 1'b0; smp();
            n_vec++;
            if ({fb_we, clear_busy, cmd_ready, fb_fifoempty} !==
                {(c >= 2 && c <= 6), (c == 7), 1'b0, (c == 7)}) begin
                n_err++;
                $display("FAIL simul_c%0d we/busy/rdy/fe: got %b expected %b", c,
                         {fb_we, clear_busy, cmd_ready, fb_fifoempty},
                         {(c >= 2 && c <= 6), (c == 7), 1'b0, (c == 7)});
            end
        end
        waited = 0;
        while (!fb_memreset && waited < 900) begin cyc(); smp(); waited++; end
        n_vec++;
        if (waited != 800) begin
            n_err++; $display("FAIL simul_sweep_len: got %0d expected 800", waited);
        end
    endtask

    task automatic test_random();
        logic in_range, prev, exp_we, done;
        int   run;
        for (int n = 0; n < 40; n++) begin
            cyc();
            cmd_valid  = 1'b1;
            cmd_x      = 7'($urandom_range(0, 87));
            cmd_y      = 6'($urandom_range(0, 63));
            cmd_rgb    = 3'($urandom);
            display_on = ($urandom_range(0, 2) == 0);
            smp();
            n_vec++;
            if (cmd_ready !== 1'b1) begin
                n_err++; $display("FAIL rnd%0d_ready: got %b expected 1", n, cmd_ready);
            end
            in_range = (cmd_x < 80) && (cmd_y < 60);
            if (!in_range) begin
                cyc(); cmd_valid = 1'b0; smp();
                n_vec++;
                if ({drop_pulse, fb_we, fb_fifoempty} !== 3'b101) begin
                    n_err++;
                    $display("FAIL rnd%0d_drop: got %b expected 101", n,
                             {drop_pulse, fb_we, fb_fifoempty});
                end
                cyc(); smp();
            end else begin
                // A write cycle needs blanking now and blanking seen on the
                // previous cycle; the write ends after 5 consecutive ones.
                prev = display_on;
                run  = 0;
                done = 1'b0;
                for (int c = 1; c <= 400 && !done; c++) begin
                    cyc(); cmd_valid = 1'b0; display_on = ($urandom_range(0, 2) == 0); smp();
                    n_vec++;
                    if (run == 5) begin
                        done = 1'b1;
                        if ({fb_we, fb_fifoempty, cmd_ready} !== 3'b011) begin
                            n_err++;
                            $display("FAIL rnd%0d_done we/fe/rdy: got %b expected 011", n,
                                     {fb_we, fb_fifoempty, cmd_ready});
                        end
                    end else begin
                        exp_we = (c >= 2) && !display_on && !prev;
                        if ({fb_we, fb_fifoempty, drop_pulse} !== {exp_we, 2'b00}) begin
                            n_err++;
                            $display("FAIL rnd%0d_c%0d we/fe/drop: got %b expected %b", n, c,
                                     {fb_we, fb_fifoempty, drop_pulse}, {exp_we, 2'b00});
                        end
                        if (exp_we) begin
                            n_vec++;
                            if ({fb_hpos, fb_vpos, fb_rgbin} !==
                                {11'(cmd_x) * 11'd8, 10'(cmd_y) * 10'd8, cmd_rgb}) begin
                                n_err++;
                                $display("FAIL rnd%0d_coords: got %0d,%0d,%0d expected %0d,%0d,%0d",
                                         n, fb_hpos, fb_vpos, fb_rgbin, cmd_x * 8, cmd_y * 8, cmd_rgb);
                            end
                        end
                        run = exp_we ? run + 1 : 0;
                    end
                    prev = display_on;
                end
                if (!done) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd%0d_timeout: got busy expected done within 400 cycles", n);
                end
            end
        end
        display_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        int waited;
        // Sweep interrupted by reset at address 400
        cyc(); clear_req = 1'b1; smp();
        cyc(); clear_req = 1'b0; smp();
        n_vec++;
        if ({clear_busy, fb_resetcnt} !== {1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL idle_clear_start: got %h expected %h", {clear_busy, fb_resetcnt}, {1'b1, 10'd0});
        end
        waited = 0;
        while (fb_resetcnt != 10'd400 && waited < 1000) begin cyc(); smp(); waited++; end
        n_vec++;
        if (fb_resetcnt !== 10'd400) begin
            n_err++; $display("FAIL reach400: got %0d expected 400", fb_resetcnt);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({fb_resetcnt, clear_busy, fb_memreset, cmd_ready} !== {10'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst_sweep: got %h expected %h",
                     {fb_resetcnt, clear_busy, fb_memreset, cmd_ready}, {10'd0, 1'b1, 1'b0, 1'b0});
        end
        cyc(); cyc(); reset_n = 1'b1; smp();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin cyc(); smp(); end
            n_vec++;
            if (fb_resetcnt !== 10'(i)) begin
                n_err++; $display("FAIL restart_cnt%0d: got %0d expected %0d", i, fb_resetcnt, i);
            end
        end
        waited = 0;
        while (!fb_memreset && waited < 900) begin cyc(); smp(); waited++; end
        // Write interrupted by reset
        display_on = 1'b0;
        cyc(); cmd_valid = 1'b1; cmd_x = 7'd10; cmd_y = 6'd20; cmd_rgb = 3'd6; smp();
        cyc(); cmd_valid = 1'b0; smp();
        cyc(); smp();
        n_vec++;
        if ({fb_we, fb_hpos, fb_vpos} !== {1'b1, 11'd80, 10'd160}) begin
            n_err++;
            $display("FAIL midwrite_pre: got %h expected %h", {fb_we, fb_hpos, fb_vpos},
                     {1'b1, 11'd80, 10'd160});
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({fb_we, fb_hpos, fb_vpos, fb_rgbin, fb_fifoempty, drop_pulse, clear_busy, fb_resetcnt} !==
            {1'b0, 11'd0, 10'd0, 3'd0, 1'b1, 1'b0, 1'b1, 10'd0}) begin
            n_err++;
            $display("FAIL async_rst_write: got %h expected %h",
                     {fb_we, fb_hpos, fb_vpos, fb_rgbin, fb_fifoempty, drop_pulse, clear_busy, fb_resetcnt},
                     {1'b0, 11'd0, 10'd0, 3'd0, 1'b1, 1'b0, 1'b1, 10'd0});
        end
        cyc(); reset_n = 1'b1; smp();
        waited = 0;
        while (!fb_memreset && waited < 900) begin cyc(); smp(); waited++; end
        n_vec++;
        if (waited != 800) begin
            n_err++; $display("FAIL post_rst_sweep_len: got %0d expected 800", waited);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_blank_interrupt();
        test_drop();
        test_clear_write();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
